// File: rtl/dma_master_arbiter.sv
// Merges NoC per-channel TileLink-UL master ports onto one system-bus master.
// A requests are arbitrated round-robin into a one-entry stage; D responses are routed back by the source tag.
module dma_master_arbiter #(
    parameter int NoC    = 1,
    parameter int TL_RS  = 4,
    parameter int MAXOUT = 4,
    localparam int CW    = (NoC > 1) ? $clog2(NoC) : 1,
    localparam int SW    = CW + TL_RS
) (
    input  logic                 dma_clock_i,
    input  logic                 dma_reset_ni,
    input  logic [3*NoC-1:0]     ca_opcode,
    input  logic [3*NoC-1:0]     ca_param,
    input  logic [4*NoC-1:0]     ca_size,
    input  logic [4*NoC-1:0]     ca_mask,
    input  logic [TL_RS*NoC-1:0] ca_source,
    input  logic [32*NoC-1:0]    ca_address,
    input  logic [32*NoC-1:0]    ca_data,
    input  logic [NoC-1:0]       ca_corrupt,
    input  logic [NoC-1:0]       ca_valid,
    output logic [NoC-1:0]       ca_ready,
    output logic [3*NoC-1:0]     cd_opcode,
    output logic [2*NoC-1:0]     cd_param,
    output logic [4*NoC-1:0]     cd_size,
    output logic [TL_RS*NoC-1:0] cd_source,
    output logic [NoC-1:0]       cd_denied,
    output logic [32*NoC-1:0]    cd_data,
    output logic [NoC-1:0]       cd_corrupt,
    output logic [NoC-1:0]       cd_valid,
    input  logic [NoC-1:0]       cd_ready,
    output logic [2:0]           m_a_opcode,
    output logic [2:0]           m_a_param,
    output logic [3:0]           m_a_size,
    output logic [SW-1:0]        m_a_source,
    output logic [31:0]          m_a_address,
    output logic [3:0]           m_a_mask,
    output logic [31:0]          m_a_data,
    output logic                 m_a_corrupt,
    output logic                 m_a_valid,
    input  logic                 m_a_ready,
    input  logic [2:0]           m_d_opcode,
    input  logic [1:0]           m_d_param,
    input  logic [3:0]           m_d_size,
    input  logic [SW-1:0]        m_d_source,
    input  logic                 m_d_denied,
    input  logic [31:0]          m_d_data,
    input  logic                 m_d_corrupt,
    input  logic                 m_d_valid,
    output logic                 m_d_ready,
    output logic                 route_err_o
);

    localparam int PW = 3 + 3 + 4 + SW + 32 + 4 + 32 + 1;

    logic [PW-1:0]   a_pay_q, a_pay_d, sel_pay;
    logic            m_a_valid_q, m_a_valid_d;
    logic [CW-1:0]   ptr_q, ptr_d;
    logic [2:0]      out_q [NoC];
    logic [2:0]      out_d [NoC];
    logic            route_err_q, route_err_d;

    logic [CW-1:0]   d_idx;
    logic            d_in_range;
    logic [NoC-1:0]  d_dec;
    logic [NoC-1:0]  eligible;
    logic [NoC-1:0]  grant;
    logic [CW-1:0]   grant_idx;
    logic            found;
    logic            stage_free;
    logic            a_fire;
    int              scan;

    // D path: pure steering by the channel tag, no storage.
    always_comb begin
        d_idx       = m_d_source[SW-1:TL_RS];
        d_in_range  = int'(d_idx) < NoC;
        m_d_ready   = 1'b1;
        cd_valid    = '0;
        for (int i = 0; i < NoC; i++) begin
            if (d_in_range && d_idx == CW'(i)) begin
                cd_valid[i] = m_d_valid;
                m_d_ready   = cd_ready[i];
            end
        end
        route_err_d = m_d_valid & ~d_in_range;
    end

    assign cd_opcode  = {NoC{m_d_opcode}};
    assign cd_param   = {NoC{m_d_param}};
    assign cd_size    = {NoC{m_d_size}};
    assign cd_source  = {NoC{m_d_source[TL_RS-1:0]}};
    assign cd_denied  = {NoC{m_d_denied}};
    assign cd_data    = {NoC{m_d_data}};
    assign cd_corrupt = {NoC{m_d_corrupt}};

    // A D beat retiring a request this cycle frees its slot for a same-cycle A accept.
    always_comb begin
        for (int i = 0; i < NoC; i++) begin
            d_dec[i]    = cd_valid[i] & cd_ready[i] & (out_q[i] != 3'd0);
            eligible[i] = ca_valid[i] & ((out_q[i] < 3'(MAXOUT)) | d_dec[i]);
        end
    end

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        scan      = 0;
        for (int k = 0; k < NoC; k++) begin
            scan = (int'(ptr_q) + k) % NoC;
            if (!found && eligible[scan]) begin
                grant[scan] = 1'b1;
                grant_idx   = CW'(scan);
                found       = 1'b1;
            end
        end
        stage_free = ~m_a_valid_q | m_a_ready;
        a_fire     = found & stage_free;
        ca_ready   = grant & {NoC{stage_free}};
    end

    always_comb begin
        sel_pay = '0;
        for (int i = 0; i < NoC; i++) begin
            if (grant[i]) begin
                sel_pay = {ca_opcode[i*3 +: 3], ca_param[i*3 +: 3], ca_size[i*4 +: 4],
                           CW'(i), ca_source[i*TL_RS +: TL_RS], ca_address[i*32 +: 32],
                           ca_mask[i*4 +: 4], ca_data[i*32 +: 32], ca_corrupt[i]};
            end
        end
    end

    // Stage reloads on the same cycle it drains, so back-to-back requests leave no bubble.
    always_comb begin
        a_pay_d     = a_pay_q;
        m_a_valid_d = m_a_valid_q;
        ptr_d       = ptr_q;
        if (a_fire) begin
            a_pay_d     = sel_pay;
            m_a_valid_d = 1'b1;
            ptr_d       = CW'((int'(grant_idx) + 1) % NoC);
        end else if (m_a_ready) begin
            m_a_valid_d = 1'b0;
        end
        for (int i = 0; i < NoC; i++) begin
            unique case ({a_fire & grant[i], d_dec[i]})
                2'b10:   out_d[i] = out_q[i] + 3'd1;
                2'b01:   out_d[i] = out_q[i] - 3'd1;
                default: out_d[i] = out_q[i];
            endcase
        end
    end

    always_ff @(posedge dma_clock_i or negedge dma_reset_ni) begin
        if (!dma_reset_ni) begin
            a_pay_q     <= '0;
            m_a_valid_q <= 1'b0;
            ptr_q       <= '0;
            route_err_q <= 1'b0;
            for (int i = 0; i < NoC; i++) begin
                out_q[i] <= 3'd0;
            end
        end else begin
            a_pay_q     <= a_pay_d;
            m_a_valid_q <= m_a_valid_d;
            ptr_q       <= ptr_d;
            route_err_q <= route_err_d;
            for (int i = 0; i < NoC; i++) begin
                out_q[i] <= out_d[i];
            end
        end
    end

    assign {m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address,
            m_a_mask, m_a_data, m_a_corrupt} = a_pay_q;
    assign m_a_valid   = m_a_valid_q;
    assign route_err_o = route_err_q;

endmodule
